// File: rtl/frame_bank_sched.sv
// Triple-buffer frame scheduler: rotates writer/reader SDRAM banks and issues
// one-cycle address reload strobes to the frame writer and frame reader.
module frame_bank_sched #(
  parameter int          FRAME_WORDS = 307200,
  parameter logic [21:0] BANK_STRIDE = 22'h080000,
  parameter logic [21:0] BASE_ADDR   = 22'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        frame_write_done,
  input  logic        frame_read_done,
  output logic [21:0] wr_addr,
  output logic [21:0] wr_max_addr,
  output logic        wr_load,
  output logic [21:0] rd_addr,
  output logic [21:0] rd_max_addr,
  output logic        rd_load,
  output logic        data_valid,
  output logic [1:0]  wr_idx,
  output logic [1:0]  rd_idx,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  repeat_cnt
);
  typedef enum logic [1:0] {WAIT_INIT, LOAD, STROBE, RUN} state_t;

  localparam logic [21:0] FRAME_LEN = 22'(FRAME_WORDS);

  state_t     state, state_next;
  logic [1:0] lat_idx, nxt_wr, nxt_rd, nxt_lat;
  logic       lat_fresh, nxt_fresh, have_frame, nxt_have;
  logic [7:0] nxt_drop, nxt_rep;
  logic       ev_wr_q, ev_rd_q, proc_ev, ev_w, ev_r;
  logic       rd_reload, wr_chg, wr_pend, rd_pend;

  function automatic logic [21:0] bank_base(input logic [1:0] idx);
    return BASE_ADDR + 22'(idx) * BANK_STRIDE;
  endfunction

  // Events are only consumed in RUN; latched pulses merge with live ones there.
  assign proc_ev = (state == RUN) && sdram_init_done;
  assign ev_w    = proc_ev && (ev_wr_q || frame_write_done);
  assign ev_r    = proc_ev && (ev_rd_q || frame_read_done);

  always_comb begin
    nxt_wr    = wr_idx;
    nxt_rd    = rd_idx;
    nxt_lat   = lat_idx;
    nxt_fresh = lat_fresh;
    nxt_have  = have_frame;
    nxt_drop  = drop_cnt;
    nxt_rep   = repeat_cnt;
    rd_reload = 1'b0;
    if (ev_w) begin
      if (!have_frame) begin
        nxt_have  = 1'b1;
        nxt_lat   = wr_idx;
        nxt_rd    = wr_idx;
        nxt_fresh = 1'b0;
        rd_reload = 1'b1;
      end else begin
        if (lat_fresh && drop_cnt != 8'hFF) nxt_drop = drop_cnt + 8'd1;
        nxt_lat   = wr_idx;
        nxt_fresh = 1'b1;
      end
    end
    // Reads before the first completed frame have nothing to display.
    if (ev_r && have_frame) begin
      rd_reload = 1'b1;
      if (nxt_fresh && nxt_lat != nxt_rd) begin
        nxt_rd    = nxt_lat;
        nxt_fresh = 1'b0;
      end else if (repeat_cnt != 8'hFF) begin
        nxt_rep = repeat_cnt + 8'd1;
      end
    end
    if (ev_w || (ev_r && have_frame)) begin
      if (nxt_lat != 2'd0 && nxt_rd != 2'd0)      nxt_wr = 2'd0;
      else if (nxt_lat != 2'd1 && nxt_rd != 2'd1) nxt_wr = 2'd1;
      else                                         nxt_wr = 2'd2;
    end
  end

  assign wr_chg = (nxt_wr != wr_idx);

  always_comb begin
    state_next = state;
    case (state)
      WAIT_INIT: if (sdram_init_done) state_next = LOAD;
      LOAD:      state_next = STROBE;
      STROBE:    state_next = RUN;
      RUN:       if (wr_chg || rd_reload) state_next = LOAD;
      default:   state_next = WAIT_INIT;
    endcase
    if (!sdram_init_done) state_next = WAIT_INIT;
  end

  assign wr_load = (state == STROBE) && wr_pend;
  assign rd_load = (state == STROBE) && rd_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_INIT;
      wr_idx      <= 2'd0;
      rd_idx      <= 2'd1;
      lat_idx     <= 2'd1;
      lat_fresh   <= 1'b0;
      have_frame  <= 1'b0;
      drop_cnt    <= 8'd0;
      repeat_cnt  <= 8'd0;
      ev_wr_q     <= 1'b0;
      ev_rd_q     <= 1'b0;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      data_valid  <= 1'b0;
      wr_addr     <= BASE_ADDR;
      wr_max_addr <= BASE_ADDR + FRAME_LEN;
      rd_addr     <= BASE_ADDR + BANK_STRIDE;
      rd_max_addr <= BASE_ADDR + BANK_STRIDE + FRAME_LEN;
    end else begin
      state      <= state_next;
      wr_idx     <= nxt_wr;
      rd_idx     <= nxt_rd;
      lat_idx    <= nxt_lat;
      lat_fresh  <= nxt_fresh;
      have_frame <= nxt_have;
      drop_cnt   <= nxt_drop;
      repeat_cnt <= nxt_rep;
      if (proc_ev) begin
        ev_wr_q <= 1'b0;
        ev_rd_q <= 1'b0;
      end else begin
        ev_wr_q <= ev_wr_q || frame_write_done;
        ev_rd_q <= ev_rd_q || frame_read_done;
      end
      // A fresh start after init always reloads both engines.
      if (state == WAIT_INIT) begin
        wr_pend <= 1'b1;
        rd_pend <= 1'b1;
      end else if (proc_ev) begin
        wr_pend <= wr_chg;
        rd_pend <= rd_reload;
      end
      // Addresses settle while in LOAD so they are stable under the strobe.
      if (state_next == LOAD) begin
        wr_addr     <= bank_base(nxt_wr);
        wr_max_addr <= bank_base(nxt_wr) + FRAME_LEN;
        rd_addr     <= bank_base(nxt_rd);
        rd_max_addr <= bank_base(nxt_rd) + FRAME_LEN;
      end
      if (!sdram_init_done)            data_valid <= 1'b0;
      else if (rd_load && have_frame)  data_valid <= 1'b1;
    end
  end
endmodule
